uart_recv: RTL and testbench

//  UART receiver (RX), 8N1, LSB first. Complement of uart_send on the same serial link.

---
 rtl/uart_recv.sv | 149 ++++++++++++++
 tb/tb_uart_recv.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// 8N1 UART receiver: 2-flop synchronized rxd, mid-bit sampling, single-cycle
// dout_valid / frame_err strobes, and a re-arm that waits for an idle (high) line.
module uart_recv #(
  parameter int CLK_FREQUENCY_HZ = 100_000_000,
  parameter int BAUD_RATE        = 1_562_500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_CYCLES  = CLK_FREQUENCY_HZ / BAUD_RATE;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CNT_W       = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       idx_reg;
  logic [1:0]       sync_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_next;
  logic [7:0]       dout_reg;
  logic             dout_valid_reg;
  logic             frame_err_reg;
  logic             busy_reg;
  logic             rxd_s;
  logic             data_tick;

  // Synchronizer resets to the idle level so release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rxd};
    end
  end

  assign rxd_s     = sync_reg[1];
  assign data_tick = (state_reg == DATA) && (cnt_reg == BIT_LAST);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_shift
      assign shift_next[gi] = (data_tick && (idx_reg == 3'(gi))) ? rxd_s : shift_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= 8'h00;
    end else begin
      shift_reg <= shift_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      idx_reg        <= 3'd0;
      dout_reg       <= 8'h00;
      dout_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      dout_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rxd_s) begin
            state_reg <= START;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            if (!rxd_s) begin
              state_reg <= DATA;
              idx_reg   <= 3'd0;
            end else begin
              // Line already back high, so IDLE cannot retrigger on this glitch.
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            if (idx_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= WAIT_IDLE;
            busy_reg  <= 1'b0;
            if (rxd_s) begin
              dout_reg       <= shift_reg;
              dout_valid_reg <= 1'b1;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          if (rxd_s) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv: bit-banged 8N1 frames on rxd, strobes tallied
// by a negedge monitor, expectations hand-computed per scenario.
module tb_uart_recv;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc            = 0;
  int fall_cyc       = 0;
  int last_valid_cyc = 0;
  int valid_cnt      = 0;
  int ferr_cnt       = 0;
  int both_cnt       = 0;
  int long_cnt       = 0;
  int busy_rise      = 0;
  logic [7:0] ferr_dout = 8'h00;
  logic prev_valid = 1'b0;
  logic prev_ferr  = 1'b0;
  logic prev_busy  = 1'b0;
  logic [7:0] rx_q[$];

  uart_recv dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dout_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      rx_q.push_back(dout);
      $display("rx byte 0x%02h at cycle %0d", dout, cyc);
    end
    if (frame_err) begin
      ferr_cnt++;
      ferr_dout = dout;
      $display("frame error at cycle %0d, dout 0x%02h", cyc, dout);
    end
    if (dout_valid && frame_err) both_cnt++;
    if ((dout_valid && prev_valid) || (frame_err && prev_ferr)) long_cnt++;
    if (busy && !prev_busy) busy_rise++;
    prev_valid = dout_valid;
    prev_ferr  = frame_err;
    prev_busy  = busy;
  end

  // Caller is at a negedge; returns at a negedge with rxd left at the stop level.
  task automatic send_byte(input logic [7:0] d, input int bc, input logic stop_bit);
    rxd = 1'b0;
    fall_cyc = cyc;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (bc) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (bc) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rxd = i[0];
      @(negedge clk);
      n_checks++;
      if ({dout, dout_valid, frame_err, busy} !== 11'h000) begin
        n_fail++;
        $display("FAIL reset_hold: got %h expected %h", {dout, dout_valid, frame_err, busy}, 11'h000);
      end
    end
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    n_checks++;
    if (dout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dout: got %h expected 00", dout);
    end
    n_checks++;
    if ((valid_cnt + ferr_cnt) !== 0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %0d expected 0", valid_cnt + ferr_cnt);
    end
  endtask

  task automatic test_single_frame();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    int b0 = busy_rise;
    rx_q.delete();
    send_byte(8'hA5, 64, 1'b1);
    repeat (64) @(negedge clk);
    n_checks++;
    if ((valid_cnt - v0) !== 1) begin
      n_fail++;
      $display("FAIL single_valid_count: got %0d expected 1", valid_cnt - v0);
    end
    n_checks++;
    if (dout !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_dout: got %h expected a5", dout);
    end
    n_checks++;
    if ((ferr_cnt - f0) !== 0) begin
      n_fail++;
      $display("FAIL single_frame_err: got %0d expected 0", ferr_cnt - f0);
    end
    n_checks++;
    if ((busy_rise - b0) !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy: got rises %0d busy %b expected 1 and 0", busy_rise - b0, busy);
    end
    // 2 sync flops + detect edge, then 32 + 9*64 clk to the stop sample.
    n_checks++;
    if ((last_valid_cyc - fall_cyc) !== 611) begin
      n_fail++;
      $display("FAIL single_latency: got %0d expected 611", last_valid_cyc - fall_cyc);
    end
  endtask

  task automatic test_glitch();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    int b0 = busy_rise;
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    n_checks++;
    if ((busy_rise - b0) !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy: got rises %0d busy %b expected 1 and 0", busy_rise - b0, busy);
    end
    n_checks++;
    if ((valid_cnt - v0) !== 0 || (ferr_cnt - f0) !== 0) begin
      n_fail++;
      $display("FAIL glitch_strobes: got valid %0d ferr %0d expected 0 0", valid_cnt - v0, ferr_cnt - f0);
    end
    n_checks++;
    if (dout !== 8'hA5) begin
      n_fail++;
      $display("FAIL glitch_dout: got %h expected a5", dout);
    end
  endtask

  task automatic test_frame_error();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    send_byte(8'h3C, 64, 1'b0);
    repeat (200) @(negedge clk);
    rxd = 1'b1;
    repeat (128) @(negedge clk);
    n_checks++;
    if ((ferr_cnt - f0) !== 1 || (valid_cnt - v0) !== 0) begin
      n_fail++;
      $display("FAIL ferr_count: got ferr %0d valid %0d expected 1 0", ferr_cnt - f0, valid_cnt - v0);
    end
    n_checks++;
    if (ferr_dout !== 8'hA5 || dout !== 8'hA5) begin
      n_fail++;
      $display("FAIL ferr_dout_kept: got %h/%h expected a5", ferr_dout, dout);
    end
    rx_q.delete();
    send_byte(8'h81, 64, 1'b1);
    repeat (64) @(negedge clk);
    n_checks++;
    if ((valid_cnt - v0) !== 1 || dout !== 8'h81) begin
      n_fail++;
      $display("FAIL ferr_recover: got count %0d dout %h expected 1 81", valid_cnt - v0, dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_slow [3] = '{8'h00, 8'hFF, 8'h55};
    logic [7:0] exp_fast [3] = '{8'hAA, 8'h0F, 8'hF0};
    int v0;
    for (int pass = 0; pass < 2; pass++) begin
      v0 = valid_cnt;
      rx_q.delete();
      for (int i = 0; i < 3; i++) begin
        send_byte(pass == 0 ? exp_slow[i] : exp_fast[i], pass == 0 ? 62 : 66, 1'b1);
      end
      repeat (128) @(negedge clk);
      n_checks++;
      if ((valid_cnt - v0) !== 3 || rx_q.size() !== 3) begin
        n_fail++;
        $display("FAIL b2b_count_pass%0d: got %0d expected 3", pass, valid_cnt - v0);
      end else begin
        for (int i = 0; i < 3; i++) begin
          n_checks++;
          if (rx_q[i] !== (pass == 0 ? exp_slow[i] : exp_fast[i])) begin
            n_fail++;
            $display("FAIL b2b_data_pass%0d_%0d: got %h expected %h", pass, i, rx_q[i],
                     pass == 0 ? exp_slow[i] : exp_fast[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'hC3;
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    rxd = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      repeat (64) @(negedge clk);
    end
    rxd = d[4];
    repeat (20) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({dout, dout_valid, frame_err, busy} !== 11'h000) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %h expected %h", {dout, dout_valid, frame_err, busy}, 11'h000);
    end
    repeat (42) @(negedge clk);
    rxd = d[5];
    repeat (64) @(negedge clk);
    rxd = d[6];
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (54) @(negedge clk);
    rxd = d[7];
    repeat (64) @(negedge clk);
    rxd = 1'b1;
    repeat (128) @(negedge clk);
    n_checks++;
    if ((valid_cnt - v0) !== 0 || (ferr_cnt - f0) !== 0) begin
      n_fail++;
      $display("FAIL midrst_no_strobe: got valid %0d ferr %0d expected 0 0", valid_cnt - v0, ferr_cnt - f0);
    end
    send_byte(8'h5A, 64, 1'b1);
    repeat (64) @(negedge clk);
    n_checks++;
    if ((valid_cnt - v0) !== 1 || dout !== 8'h5A) begin
      n_fail++;
      $display("FAIL midrst_recover: got count %0d dout %h expected 1 5a", valid_cnt - v0, dout);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] sent[$];
    logic [7:0] b;
    int v0 = valid_cnt;
    rx_q.delete();
    for (int i = 0; i < 32; i++) begin
      b = 8'($urandom_range(0, 255));
      sent.push_back(b);
      send_byte(b, 64, 1'b1);
    end
    repeat (128) @(negedge clk);
    n_checks++;
    if ((valid_cnt - v0) !== 32 || rx_q.size() !== 32) begin
      n_fail++;
      $display("FAIL loop_count: got %0d expected 32", valid_cnt - v0);
    end else begin
      for (int i = 0; i < 32; i++) begin
        n_checks++;
        if (rx_q[i] !== sent[i]) begin
          n_fail++;
          $display("FAIL loop_data_%0d: got %h expected %h", i, rx_q[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_strobe_shape();
    n_checks++;
    if (both_cnt !== 0) begin
      n_fail++;
      $display("FAIL strobe_overlap: got %0d expected 0", both_cnt);
    end
    n_checks++;
    if (long_cnt !== 0) begin
      n_fail++;
      $display("FAIL strobe_width: got %0d multi-cycle strobes expected 0", long_cnt);
    end
  endtask

  initial begin
    rst = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    test_strobe_shape();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
